seq_arith_unit: RTL and testbench
=================================

SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 19, as the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a request is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port op, input, 3 bits, encoded 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 INC, 101 DEC, 110/111 reserved.
REQ-007 The block SHALL have ports operand_1 and operand_2, inputs, WIDTH bits each: unsigned operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a result is held on the outputs.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have ports result and remainder, outputs, WIDTH bits each; remainder is meaningful for DIV only and 0 otherwise.
REQ-011 The block SHALL have ports carry, zero, overflow, div_by_zero and illegal_op, outputs, 1 bit each: status flags.

Function
REQ-012 Control SHALL be an FSM with states IDLE, CALC and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where in_valid=1 and in_ready=1, and op and both operands are registered at that edge.
REQ-014 ADD, SUB, INC, DEC, reserved ops and DIV with operand_2=0 SHALL complete at the accept edge (IDLE->DONE), with out_valid=1 in the next cycle.
REQ-015 MUL and DIV with a nonzero divisor SHALL go IDLE->CALC, perform exactly WIDTH iterations, one per edge, then go CALC->DONE; out_valid=1 exactly WIDTH cycles after the accept edge.
REQ-016 ADD/INC SHALL produce result = low WIDTH bits of the sum, with carry = bit WIDTH of the sum; INC uses operand_2 = 1 and ignores the operand_2 port.
REQ-017 SUB/DEC SHALL produce result = operand_1 - operand_2 mod 2^WIDTH, with carry = borrow (1 when operand_1 < subtrahend); DEC uses subtrahend 1.
REQ-018 MUL SHALL be shift-and-add, producing result = low WIDTH bits of the 2*WIDTH product, overflow=1 if any high WIDTH bits are nonzero, and carry=0.
REQ-019 DIV SHALL be restoring, MSB first, producing result = floor(operand_1/operand_2), remainder = operand_1 mod operand_2, and carry=0.
REQ-020 DIV by zero SHALL produce result = all ones, remainder = operand_1, div_by_zero=1, and no CALC state.
REQ-021 Reserved op SHALL produce result=0, remainder=0, illegal_op=1 and zero=0.
REQ-022 zero SHALL be 1 when result==0, except for a reserved op.
REQ-023 Flags not defined for an op SHALL be 0.
REQ-024 In DONE, result, remainder, flags and out_valid SHALL be held stable until an edge with out_ready=1, which moves DONE->IDLE and clears out_valid.
REQ-025 Request and completion are never both handled in one cycle: in_ready=0 during DONE, so a new request is accepted no earlier than the cycle after the handshake.
REQ-026 in_valid, op and operand changes during CALC or DONE SHALL have no effect.

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE and in_ready=1, with out_valid, result, remainder, carry, zero, overflow, div_by_zero, illegal_op and the iteration counter all 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation immediately, discard the result and leave no residual state.
REQ-029 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-030 The bench SHALL cover ADD 0x7FFFF + 0x00001 (WIDTH=19) -> next cycle out_valid=1, result=0, carry=1, zero=1.
REQ-031 The bench SHALL cover MUL 1000 x 300 -> out_valid exactly 19 cycles after accept, result=300000, overflow=0, with in_ready=0 throughout.
REQ-032 The bench SHALL cover MUL 1024 x 1024 -> result=0, overflow=1, zero=1.
REQ-033 The bench SHALL cover DIV 100 / 7 -> result=14, remainder=2, and DIV 5 / 0 -> next cycle result=0x7FFFF, remainder=5, div_by_zero=1.
REQ-034 The bench SHALL cover SUB 3 - 5 with out_ready held 0 for 10 cycles -> result=0x7FFFE, carry=1, stable for all 10 cycles, then IDLE one edge after out_ready=1.
REQ-035 The bench SHALL cover rst_n pulsed low at iteration 8 of a DIV -> out_valid=0 immediately, and a following ADD 2+2 gives result=4 at the normal latency.

Source files
------------

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: single-cycle add/sub/inc/dec, iterative shift-and-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module seq_arith_unit #(
  parameter int unsigned WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpInc = 3'b100;
  localparam logic [2:0] OpDec = 3'b101;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;
  logic               dbz_q, dbz_d;
  logic               illegal_q, illegal_d;

  // Single-cycle datapath, fed straight from the ports at the accept edge.
  logic [WIDTH-1:0] step_operand;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  assign step_operand = (op == OpInc || op == OpDec) ? {{(WIDTH-1){1'b0}}, 1'b1} : operand_2;
  assign sum_ext      = {1'b0, operand_1} + {1'b0, step_operand};
  assign diff_ext     = {1'b0, operand_1} - {1'b0, step_operand};

  // One multiply iteration: add the shifted multiplicand when the current multiplier bit is set.
  logic [2*WIDTH-1:0] prod_step;
  assign prod_step = acc_q + (b_q[0] ? mcand_q : '0);

  // One restoring-divide iteration: the dividend register shifts left and collects quotient bits.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign rem_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, b_q};
  assign q_bit     = ~trial[WIDTH];
  assign rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next  = {a_q[WIDTH-2:0], q_bit};

  logic last_iter;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    illegal_d   = illegal_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d        = op;
          a_d         = operand_1;
          b_d         = operand_2;
          acc_d       = '0;
          mcand_d     = {{WIDTH{1'b0}}, operand_1};
          cnt_d       = '0;
          result_d    = '0;
          remainder_d = '0;
          carry_d     = 1'b0;
          zero_d      = 1'b0;
          overflow_d  = 1'b0;
          dbz_d       = 1'b0;
          illegal_d   = 1'b0;
          state_d     = StDone;
          case (op)
            OpAdd, OpInc: begin
              result_d = sum_ext[WIDTH-1:0];
              carry_d  = sum_ext[WIDTH];
              zero_d   = (sum_ext[WIDTH-1:0] == '0);
            end
            OpSub, OpDec: begin
              result_d = diff_ext[WIDTH-1:0];
              carry_d  = diff_ext[WIDTH];
              zero_d   = (diff_ext[WIDTH-1:0] == '0);
            end
            OpMul: state_d = StCalc;
            OpDiv: begin
              if (operand_2 == '0) begin
                result_d    = '1;
                remainder_d = operand_1;
                dbz_d       = 1'b1;
              end else begin
                state_d = StCalc;
              end
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end

      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (op_q == OpMul) begin
          acc_d   = prod_step;
          mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
          b_d     = {1'b0, b_q[WIDTH-1:1]};
        end else begin
          acc_d = {{WIDTH{1'b0}}, rem_next};
          a_d   = quo_next;
        end
        if (last_iter) begin
          state_d = StDone;
          if (op_q == OpMul) begin
            result_d   = prod_step[WIDTH-1:0];
            overflow_d = (prod_step[2*WIDTH-1:WIDTH] != '0);
            zero_d     = (prod_step[WIDTH-1:0] == '0);
          end else begin
            result_d    = quo_next;
            remainder_d = rem_next;
            zero_d      = (quo_next == '0);
          end
        end
      end

      StDone: begin
        if (out_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign result      = result_q;
  assign remainder   = remainder_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit: directed vector table, hand-written reset and
// back-pressure sequences, and randomized operations against an arithmetic reference model.
module tb_seq_arith_unit;

  localparam int W = 19;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         c;
    logic         z;
    logic         ov;
    logic         dbz;
    logic         ill;
    int           lat;
  } exp_t;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           hold;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] operand_1;
  logic [W-1:0] operand_2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;
  logic         illegal_op;

  int total = 0;
  int bad   = 0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .operand_1   (operand_1),
    .operand_2   (operand_2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .remainder   (remainder),
    .carry       (carry),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model built directly from the arithmetic definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned a, b, m, r;
    a = 64'(x);
    b = 64'(y);
    m = (64'd1 << W) - 1;
    e.res = '0; e.rem = '0; e.c = 0; e.z = 0; e.ov = 0; e.dbz = 0; e.ill = 0; e.lat = 0;
    case (o)
      3'd0, 3'd4: begin
        if (o == 3'd4) b = 1;
        r = a + b;
        e.res = W'(r & m);
        e.c = ((r >> W) != 0);
      end
      3'd1, 3'd5: begin
        if (o == 3'd5) b = 1;
        e.res = W'((a - b) & m);
        e.c = (a < b);
      end
      3'd2: begin
        r = a * b;
        e.res = W'(r & m);
        e.ov = ((r >> W) != 0);
        e.lat = W;
      end
      3'd3: begin
        if (b == 0) begin
          e.res = W'(m);
          e.rem = W'(a);
          e.dbz = 1;
        end else begin
          e.res = W'(a / b);
          e.rem = W'(a % b);
          e.lat = W;
        end
      end
      default: e.ill = 1;
    endcase
    e.z = (o <= 3'd5) && (e.res == '0);
    return e;
  endfunction

  task automatic scramble();
    in_valid  = 1'($urandom);
    op        = 3'($urandom);
    operand_1 = W'($urandom);
    operand_2 = W'($urandom);
  endtask

  // Issue one request at the next edge, measure latency, check results, hold, then hand off.
  task automatic apply(input string name, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input exp_t e, input int hold);
    int lat;
    bit busy_bad;
    logic [63:0] got_pk, exp_pk;
    check({name, ".ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    op        = o;
    operand_1 = x;
    operand_2 = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_bad = 1;
      scramble();
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".lat"}, 64'(lat), 64'(e.lat));
    check({name, ".busy"}, 64'(busy_bad), 64'd0);
    check({name, ".res"}, 64'(result), 64'(e.res));
    check({name, ".rem"}, 64'(remainder), 64'(e.rem));
    check({name, ".flags"}, 64'({carry, zero, overflow, div_by_zero, illegal_op}),
          64'({e.c, e.z, e.ov, e.dbz, e.ill}));
    exp_pk = 64'({1'b1, e.res, e.rem, e.c, e.z, e.ov, e.dbz, e.ill});
    for (int h = 0; h < hold; h++) begin
      scramble();
      @(posedge clk); #1;
      got_pk = 64'({out_valid, result, remainder, carry, zero, overflow, div_by_zero, illegal_op});
      check({name, ".hold"}, got_pk, exp_pk);
    end
    out_ready = 1'b1;
    scramble();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, ".idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{"add_wrap", 3'd0, 19'h7FFFF, 19'h00001, '{19'h0, 19'h0, 1, 1, 0, 0, 0, 0}, 0};
    vecs[1]  = '{"mul_300k", 3'd2, 19'd1000, 19'd300, '{19'd300000, 19'h0, 0, 0, 0, 0, 0, 19}, 0};
    vecs[2]  = '{"mul_ovf", 3'd2, 19'd1024, 19'd1024, '{19'h0, 19'h0, 0, 1, 1, 0, 0, 19}, 1};
    vecs[3]  = '{"div_100_7", 3'd3, 19'd100, 19'd7, '{19'd14, 19'd2, 0, 0, 0, 0, 0, 19}, 2};
    vecs[4]  = '{"div_by0", 3'd3, 19'd5, 19'd0, '{19'h7FFFF, 19'd5, 0, 0, 0, 1, 0, 0}, 0};
    vecs[5]  = '{"sub_neg", 3'd1, 19'd3, 19'd5, '{19'h7FFFE, 19'h0, 1, 0, 0, 0, 0, 0}, 10};
    vecs[6]  = '{"inc_wrap", 3'd4, 19'h7FFFF, 19'd123, '{19'h0, 19'h0, 1, 1, 0, 0, 0, 0}, 0};
    vecs[7]  = '{"dec_zero", 3'd5, 19'd0, 19'd77, '{19'h7FFFF, 19'h0, 1, 0, 0, 0, 0, 0}, 0};
    vecs[8]  = '{"rsv6", 3'd6, 19'd9, 19'd9, '{19'h0, 19'h0, 0, 0, 0, 0, 1, 0}, 0};
    vecs[9]  = '{"rsv7", 3'd7, 19'd0, 19'd0, '{19'h0, 19'h0, 0, 0, 0, 0, 1, 0}, 1};
    vecs[10] = '{"div_small", 3'd3, 19'd3, 19'd7, '{19'h0, 19'd3, 0, 1, 0, 0, 0, 19}, 0};
    vecs[11] = '{"mul_max", 3'd2, 19'h7FFFF, 19'h7FFFF, '{19'h1, 19'h0, 0, 0, 1, 0, 0, 19}, 0};
    vecs[12] = '{"sub_eq", 3'd1, 19'd5, 19'd5, '{19'h0, 19'h0, 0, 1, 0, 0, 0, 0}, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; operand_1 = '0; operand_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.hs", 64'({in_ready, out_valid}), 64'b10);
    check("reset.out", 64'({result, remainder, carry, zero, overflow, div_by_zero, illegal_op}),
          64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e,
                            vecs[i].hold);

    // Abort a divide mid-iteration, then confirm nothing leaks into the following requests.
    check("abort.ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = 3'd3; operand_1 = 19'd1000; operand_2 = 19'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.hs", 64'({in_ready, out_valid}), 64'b10);
    check("abort.out", 64'({result, remainder, carry, zero, overflow, div_by_zero, illegal_op}),
          64'd0);
    #2;
    rst_n = 1'b1;
    apply("post_add", 3'd0, 19'd2, 19'd2, model(3'd0, 19'd2, 19'd2), 0);
    apply("post_div", 3'd3, 19'd1000, 19'd3, model(3'd3, 19'd1000, 19'd3), 0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin ra = W'($urandom); rb = W'($urandom); end
        1: begin ra = W'($urandom_range(0, 15)); rb = W'($urandom_range(0, 15)); end
        2: begin ra = '1; rb = W'($urandom); end
        default: begin ra = W'($urandom); rb = W'($urandom_range(0, 1)); end
      endcase
      apply("rand", ro, ra, rb, model(ro, ra, rb), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
